hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//   ID-stage hazard detector; produces stall and bubble requests for the pipeline.
//   Drives PC_stall and IF_ID_stall to the PC and IF/ID registers, and ID_EX_clr_tmp,
//   which ClrControl ORs into ID_EX_clr.
//   Covers load-use, branch-in-ID operand and multi-cycle MULT/DIV (HI/LO) hazards.
//   Tracks MDU occupancy with a latency counter and counts stall cycles for profiling.
// PARAMETERS
//   MULT_LAT  4   cycles until HI/LO valid after a MULT/MULTU leaves ID
//   DIV_LAT   32  cycles until HI/LO valid after a DIV/DIVU leaves ID
//   CNT_W     6   MDU counter width; must hold max(MULT_LAT, DIV_LAT)
//   PERF_W    16  stall performance counter width
// PORTS
//   clk            in   1       clock, rising edge
//   rst            in   1       synchronous, active-high reset
//   ID_rs, ID_rt   in   5 each  source register numbers of the instruction in ID
//   ID_use_rs/rt   in   1 each  instruction in ID reads rs / rt
//   ID_is_branch   in   1       ID instr is a branch/jr that compares operands in ID
//   ID_md_start    in   1       ID instr is MULT/MULTU/DIV/DIVU
//   ID_md_div      in   1       1 = DIV/DIVU, 0 = MULT/MULTU (valid with ID_md_start)
//   ID_hilo_rd     in   1       ID instr is MFHI/MFLO
//   EX_RegWrite    in   1       instruction in EX writes the register file
//   EX_MemRead     in   1       instruction in EX is a load
//   EX_wa          in   5       destination register of EX instruction
//   MEM_MemRead    in   1       instruction in MEM is a load
//   MEM_wa         in   5       destination register of MEM instruction
//   PC_stall       out  1       hold PC
//   IF_ID_stall    out  1       hold IF/ID register
//   ID_EX_clr_tmp  out  1       insert bubble into ID/EX
//   md_busy        out  1       MDU result pending (state == MD_BUSY)
//   stall_cycles   out  PERF_W  saturating count of stalled cycles
// BEHAVIOUR
//   Reset: state=IDLE, md_cnt=0, stall_cycles=0. While rst=1, all stall outputs are 0.
//   match(r) = use && r==wa && wa!=0. Register $0 never causes a hazard.
//   Hazard terms, all combinational on the current cycle:
//     lu  = EX_MemRead && (match rs || match rt)                 load-use, 1 bubble
//     br1 = ID_is_branch && EX_RegWrite && (match rs||rt vs EX_wa)
//     br2 = ID_is_branch && MEM_MemRead && (match rs||rt vs MEM_wa)
//     md  = md_busy && (ID_hilo_rd || ID_md_start)               no overlapping MDU ops
//   stall = lu|br1|br2|md. The three outputs are equal to stall; this is the same cycle, with no latency.
//   Simultaneous hazards produce a single stall; there is no priority.
//   A branch stalled by lu then br2 gets 2 bubbles in total.
//   MDU FSM has two states, IDLE and MD_BUSY:
//     accept = ID_md_start && !stall. On accept, md_cnt <= ID_md_div ? DIV_LAT : MULT_LAT.
//     IDLE -> MD_BUSY on accept.
//     MD_BUSY: md_cnt decrements each cycle. On the clock edge where md_cnt==1:
//       next state IDLE and md_cnt 0, unless accept on that same edge.
//     Example: MULT accepted at cycle 0 gives md_busy=1 in cycles 1..4 and 0 in cycle 5.
//       An MFHI in ID during cycles 1..4 stalls; it proceeds in cycle 5.
//   stall_cycles increments each cycle stall=1. It saturates at all-ones and never wraps.
//   Reset mid-operation aborts the MDU count: md_busy=0 on the next cycle.
//   Out-of-range latency (more than 2^CNT_W-1) is a parameter error and is checked at elaboration.
// STRUCTURE
//   hazard_defs.vh (shared include): FSM state encodings and default MULT_LAT/DIV_LAT.
//     ALU/MDU models use the same include.
//   Sub-module md_latency_cnt holds the FSM, md_cnt and md_busy.
//     Inputs: load, div, rst. Output: busy.
//   Top level holds the comparators, the stall OR and the perf counter.
// TESTING
//   1 Load then use: EX_MemRead=1, EX_wa=8, ID_rs=8, ID_use_rs=1.
//     -> all three stall outputs =1 for 1 cycle; stall_cycles 0->1.
//   2 Zero register: load with EX_wa=0 and ID_rs=0 -> no stall. Non-load EX_wa=8, ID_rs=8, non-branch -> no stall.
//   3 BEQ reading $9, ALU writes $9 in EX -> 1 stall. Same BEQ with lw $9 in EX -> 2 stalls (lu, then br2).
//   4 MULT accepted at cycle 0, MFLO in ID at cycle 1 -> stall cycles 1..4, release cycle 5. DIV -> 32-cycle stall.
//   5 DIV in ID while load-use stall is active -> not accepted, md_busy stays 0.
//     DIV accepted the next cycle -> md_busy=1.
//   6 rst=1 at cycle 10 of a DIV -> md_busy=0 and stall_cycles=0 the next cycle. Saturation: force 2^16+3 stall cycles -> 16'hFFFF.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared MDU state encoding, default latencies and register-match helper
package hazard_ctrl_pkg;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_e;

   localparam int DEF_MULT_LAT = 4;
   localparam int DEF_DIV_LAT  = 32;
   localparam int DEF_CNT_W    = 6;
   localparam int DEF_PERF_W   = 16;

   // $0 is hardwired to zero, so a write to it can never create a dependency.
   function automatic logic reg_match(input logic rd_en, input logic [4:0] r, input logic [4:0] wa);
      return rd_en && (r == wa) && (wa != 5'd0);
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - ID/EX/MEM hazard inputs and stall outputs of the hazard controller
interface hazard_ctrl_if #(
   parameter int PERF_W = 16
);
   logic [4:0]        ID_rs;
   logic [4:0]        ID_rt;
   logic              ID_use_rs;
   logic              ID_use_rt;
   logic              ID_is_branch;
   logic              ID_md_start;
   logic              ID_md_div;
   logic              ID_hilo_rd;
   logic              EX_RegWrite;
   logic              EX_MemRead;
   logic [4:0]        EX_wa;
   logic              MEM_MemRead;
   logic [4:0]        MEM_wa;
   logic              PC_stall;
   logic              IF_ID_stall;
   logic              ID_EX_clr_tmp;
   logic              md_busy;
   logic [PERF_W-1:0] stall_cycles;

   modport master (
      output ID_rs, ID_rt, ID_use_rs, ID_use_rt, ID_is_branch,
             ID_md_start, ID_md_div, ID_hilo_rd,
             EX_RegWrite, EX_MemRead, EX_wa, MEM_MemRead, MEM_wa,
      input  PC_stall, IF_ID_stall, ID_EX_clr_tmp, md_busy, stall_cycles
   );

   modport slave (
      input  ID_rs, ID_rt, ID_use_rs, ID_use_rt, ID_is_branch,
             ID_md_start, ID_md_div, ID_hilo_rd,
             EX_RegWrite, EX_MemRead, EX_wa, MEM_MemRead, MEM_wa,
      output PC_stall, IF_ID_stall, ID_EX_clr_tmp, md_busy, stall_cycles
   );

endinterface

// File: rtl/hazard_ctrl_md_latency_cnt.sv
// rtl/hazard_ctrl_md_latency_cnt.sv - MDU occupancy FSM; busy for exactly LAT cycles after a load
module hazard_ctrl_md_latency_cnt
   import hazard_ctrl_pkg::*;
#(
   parameter int MULT_LAT = DEF_MULT_LAT,
   parameter int DIV_LAT  = DEF_DIV_LAT,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   input  logic div_i,
   output logic busy_o
);

   md_state_e        state_q;
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= MD_IDLE;
         cnt_q   <= '0;
      end else if (load_i) begin
         state_q <= MD_BUSY;
         cnt_q   <= div_i ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
      end else if (state_q == MD_BUSY) begin
         if (cnt_q == CNT_W'(1)) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
         end else begin
            cnt_q   <= cnt_q - CNT_W'(1);
         end
      end
   end

   assign busy_o = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - ID-stage hazard detector: load-use, branch operand and HI/LO stalls
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MULT_LAT = DEF_MULT_LAT,
   parameter int DIV_LAT  = DEF_DIV_LAT,
   parameter int CNT_W    = DEF_CNT_W,
   parameter int PERF_W   = DEF_PERF_W
) (
   input  logic          clk,
   input  logic          rst,
   hazard_ctrl_if.slave  hz
);

   if ((MULT_LAT > (2 ** CNT_W) - 1) || (DIV_LAT > (2 ** CNT_W) - 1)) begin : g_lat_range_err
      $error("hazard_ctrl: MULT_LAT/DIV_LAT do not fit in CNT_W bits");
   end

   logic              src_ex;
   logic              src_mem;
   logic              lu;
   logic              br1;
   logic              br2;
   logic              md;
   logic              stall;
   logic              accept;
   logic              md_busy;
   logic [PERF_W-1:0] stall_cycles_q;
   logic [PERF_W-1:0] stall_cycles_d;

   assign src_ex  = reg_match(hz.ID_use_rs, hz.ID_rs, hz.EX_wa)
                  | reg_match(hz.ID_use_rt, hz.ID_rt, hz.EX_wa);
   assign src_mem = reg_match(hz.ID_use_rs, hz.ID_rs, hz.MEM_wa)
                  | reg_match(hz.ID_use_rt, hz.ID_rt, hz.MEM_wa);

   assign lu  = hz.EX_MemRead & src_ex;
   assign br1 = hz.ID_is_branch & hz.EX_RegWrite & src_ex;
   assign br2 = hz.ID_is_branch & hz.MEM_MemRead & src_mem;
   assign md  = md_busy & (hz.ID_hilo_rd | hz.ID_md_start);

   // Outputs are forced low during reset so the pipeline never freezes on stale inputs.
   assign stall  = ~rst & (lu | br1 | br2 | md);
   assign accept = hz.ID_md_start & ~stall;

   hazard_ctrl_md_latency_cnt #(
      .MULT_LAT (MULT_LAT),
      .DIV_LAT  (DIV_LAT),
      .CNT_W    (CNT_W)
   ) u_md_cnt (
      .clk    (clk),
      .rst    (rst),
      .load_i (accept),
      .div_i  (hz.ID_md_div),
      .busy_o (md_busy)
   );

   assign stall_cycles_d = (stall && (stall_cycles_q != '1)) ? stall_cycles_q + PERF_W'(1)
                                                              : stall_cycles_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles_q <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign hz.PC_stall      = stall;
   assign hz.IF_ID_stall   = stall;
   assign hz.ID_EX_clr_tmp = stall;
   assign hz.md_busy       = md_busy;
   assign hz.stall_cycles  = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl against a cycle-level reference model
module tb_hazard_ctrl;

   typedef struct {
      logic       rst;
      logic [4:0] rs, rt, ex_wa, mem_wa;
      logic       use_rs, use_rt, is_branch, md_start, md_div, hilo_rd;
      logic       ex_rw, ex_mr, mem_mr;
   } stim_t;

   typedef struct {
      int   cyc;
      logic stall;
      logic busy;
      int   perf;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   hazard_ctrl_if #(.PERF_W(16)) hz ();

   hazard_ctrl #(
      .MULT_LAT (4),
      .DIV_LAT  (32),
      .CNT_W    (6),
      .PERF_W   (16)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz.slave)
   );

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   // Reference state: cycles of MDU occupancy still ahead, and the profiling count.
   int md_left = 0;
   int perf    = 0;

   function automatic stim_t idle();
      stim_t s;
      s = '{rst: 1'b0, rs: 5'd0, rt: 5'd0, ex_wa: 5'd0, mem_wa: 5'd0,
            use_rs: 1'b0, use_rt: 1'b0, is_branch: 1'b0, md_start: 1'b0, md_div: 1'b0,
            hilo_rd: 1'b0, ex_rw: 1'b0, ex_mr: 1'b0, mem_mr: 1'b0};
      return s;
   endfunction

   function automatic bit dep(input stim_t s, input logic [4:0] wa);
      return wa != 0 && ((s.use_rs && s.rs == wa) || (s.use_rt && s.rt == wa));
   endfunction

   task automatic step(input stim_t s);
      exp_t e;
      bit   hzd;
      @(posedge clk);
      #1;
      rst             = s.rst;
      hz.ID_rs        = s.rs;
      hz.ID_rt        = s.rt;
      hz.ID_use_rs    = s.use_rs;
      hz.ID_use_rt    = s.use_rt;
      hz.ID_is_branch = s.is_branch;
      hz.ID_md_start  = s.md_start;
      hz.ID_md_div    = s.md_div;
      hz.ID_hilo_rd   = s.hilo_rd;
      hz.EX_RegWrite  = s.ex_rw;
      hz.EX_MemRead   = s.ex_mr;
      hz.EX_wa        = s.ex_wa;
      hz.MEM_MemRead  = s.mem_mr;
      hz.MEM_wa       = s.mem_wa;
      hzd = (s.ex_mr && dep(s, s.ex_wa))
         || (s.is_branch && s.ex_rw && dep(s, s.ex_wa))
         || (s.is_branch && s.mem_mr && dep(s, s.mem_wa))
         || (md_left > 0 && (s.hilo_rd || s.md_start));
      e.cyc   = cyc;
      e.stall = !s.rst && hzd;
      e.busy  = md_left > 0;
      e.perf  = perf;
      exp_q.push_back(e);
      if (s.rst) begin
         md_left = 0;
         perf    = 0;
      end else begin
         if (s.md_start && !e.stall) md_left = s.md_div ? 32 : 4;
         else if (md_left > 0)       md_left = md_left - 1;
         if (e.stall && perf < 65535) perf = perf + 1;
      end
      cyc++;
   endtask

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_cmp++;
         if ({hz.PC_stall, hz.IF_ID_stall, hz.ID_EX_clr_tmp} !== {3{e.stall}}) begin
            n_bad++;
            $display("FAIL stall_outs cyc=%0d got=%b%b%b want=%b", e.cyc,
                     hz.PC_stall, hz.IF_ID_stall, hz.ID_EX_clr_tmp, e.stall);
         end
         n_cmp++;
         if (hz.md_busy !== e.busy) begin
            n_bad++;
            $display("FAIL md_busy cyc=%0d got=%b want=%b", e.cyc, hz.md_busy, e.busy);
         end
         n_cmp++;
         if (hz.stall_cycles !== 16'(e.perf)) begin
            n_bad++;
            $display("FAIL stall_cycles cyc=%0d got=%0d want=%0d", e.cyc, hz.stall_cycles, e.perf);
         end
      end
   end

   initial begin
      stim_t s;
      s = idle();
      s.rst = 1'b1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      step(s);
      step(idle());

      // Load-use on rs, then on rt.
      s = idle(); s.ex_mr = 1; s.ex_wa = 8; s.rs = 8; s.use_rs = 1; step(s);
      s = idle(); s.ex_mr = 1; s.ex_wa = 7; s.rt = 7; s.use_rt = 1; step(s);
      step(idle());

      // $0 never matches; non-load ALU writer ahead of a non-branch never stalls.
      s = idle(); s.ex_mr = 1; s.ex_wa = 0; s.rs = 0; s.use_rs = 1; step(s);
      s = idle(); s.ex_rw = 1; s.ex_wa = 8; s.rs = 8; s.use_rs = 1; step(s);

      // Branch vs ALU in EX, then branch vs load (lu then br2).
      s = idle(); s.is_branch = 1; s.rs = 9; s.use_rs = 1; s.ex_rw = 1; s.ex_wa = 9; step(s);
      step(idle());
      s = idle(); s.is_branch = 1; s.rs = 9; s.use_rs = 1; s.ex_rw = 1; s.ex_mr = 1; s.ex_wa = 9; step(s);
      s = idle(); s.is_branch = 1; s.rs = 9; s.use_rs = 1; s.mem_mr = 1; s.mem_wa = 9; step(s);
      s = idle(); s.is_branch = 1; s.rs = 9; s.use_rs = 1; step(s);

      // MULT then MFLO held in ID until release; then DIV the same way.
      s = idle(); s.md_start = 1; step(s);
      s = idle(); s.hilo_rd = 1;
      repeat (5) step(s);
      s = idle(); s.md_start = 1; s.md_div = 1; step(s);
      s = idle(); s.hilo_rd = 1;
      repeat (34) step(s);

      // DIV blocked by load-use, accepted next cycle.
      s = idle(); s.md_start = 1; s.md_div = 1; s.ex_mr = 1; s.ex_wa = 8; s.rs = 8; s.use_rs = 1; step(s);
      s = idle(); s.md_start = 1; s.md_div = 1; step(s);
      s = idle(); s.md_start = 1; s.md_div = 1;
      repeat (9) step(s);

      // Reset in the middle of the DIV.
      s = idle(); s.rst = 1; s.hilo_rd = 1; s.ex_mr = 1; s.ex_wa = 3; s.rs = 3; s.use_rs = 1; step(s);
      s = idle(); s.hilo_rd = 1; step(s);
      step(idle());

      // Randomised mix over a small register range to provoke matches.
      for (int i = 0; i < 3000; i++) begin
         s.rst       = ($urandom_range(0, 199) == 0);
         s.rs        = 5'($urandom_range(0, 3));
         s.rt        = 5'($urandom_range(0, 3));
         s.ex_wa     = 5'($urandom_range(0, 3));
         s.mem_wa    = 5'($urandom_range(0, 3));
         s.use_rs    = 1'($urandom);
         s.use_rt    = 1'($urandom);
         s.is_branch = ($urandom_range(0, 3) == 0);
         s.md_start  = ($urandom_range(0, 5) == 0);
         s.md_div    = ($urandom_range(0, 3) == 0);
         s.hilo_rd   = ($urandom_range(0, 3) == 0);
         s.ex_rw     = 1'($urandom);
         s.ex_mr     = ($urandom_range(0, 3) == 0);
         s.mem_mr    = ($urandom_range(0, 3) == 0);
         step(s);
      end

      // Saturation: reset the counter, then 2^16+3 consecutive stall cycles.
      s = idle(); s.rst = 1; step(s);
      s = idle(); s.ex_mr = 1; s.ex_wa = 5; s.rs = 5; s.use_rs = 1;
      for (int i = 0; i < 65539; i++) step(s);
      step(idle());

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
      @(negedge clk);
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain got=%0d pending want=0", exp_q.size());
      end
      if (perf != 65535) begin
         n_bad++;
         $display("FAIL sat_model got=%0d want=65535", perf);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
